// File: rtl/div_rasterizer_client.sv
// Rasterizer divider client: issues N_OPS divides, collects and converts results.
// Define DIV_RASTERIZER_CLIENT_SAT_EN to saturate out-of-range results.
module div_rasterizer_client #(
  parameter int N_OPS            = 3,
  parameter int FRACTIONAL_WIDTH = 17,
  parameter int OUT_W            = 32,
  parameter int OUT_FRAC         = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [N_OPS*64-1:0]    job_dividend,
  input  logic [N_OPS*64-1:0]    job_divisor,
  output logic                   m_axis_dividend_tvalid,
  input  logic                   m_axis_dividend_tready,
  output logic [63:0]            m_axis_dividend_tdata,
  output logic                   m_axis_divisor_tvalid,
  input  logic                   m_axis_divisor_tready,
  output logic [63:0]            m_axis_divisor_tdata,
  input  logic                   s_axis_dout_tvalid,
  output logic                   s_axis_dout_tready,
  input  logic                   s_axis_dout_tuser,
  input  logic [87:0]            s_axis_dout_tdata,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [N_OPS*OUT_W-1:0] res_data,
  output logic [N_OPS-1:0]       res_dbz,
  output logic                   busy
);

  localparam int IW = $clog2(N_OPS + 1);
  localparam int SH = FRACTIONAL_WIDTH - OUT_FRAC;
  localparam logic [IW-1:0] NI = IW'(N_OPS);
  localparam logic [OUT_W-1:0] MAXV = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MINV = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_t;

  state_t                   state_q, state_d;
  logic [N_OPS*64-1:0]      dvd_q, dvd_d;
  logic [N_OPS*64-1:0]      dvs_q, dvs_d;
  logic [IW-1:0]            dvd_idx_q, dvd_idx_d;
  logic [IW-1:0]            dvs_idx_q, dvs_idx_d;
  logic [IW-1:0]            ret_idx_q, ret_idx_d;
  logic [N_OPS*OUT_W-1:0]   res_q, res_d;
  logic [N_OPS-1:0]         dbz_q, dbz_d;

  logic                     dvd_vld, dvs_vld, ret_rdy;
  logic                     dvd_hs, dvs_hs, ret_hs;
  logic [63:0]              dvd_sel, dvs_sel;
  logic signed [80:0]       q_s, s_s;
  logic                     dvd_neg;
  logic [OUT_W-1:0]         conv;
  logic                     unused_bits;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      dvd_idx_q <= '0;
      dvs_idx_q <= '0;
      ret_idx_q <= '0;
      res_q     <= '0;
      dbz_q     <= '0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      dvd_idx_q <= dvd_idx_d;
      dvs_idx_q <= dvs_idx_d;
      ret_idx_q <= ret_idx_d;
      res_q     <= res_d;
      dbz_q     <= dbz_d;
    end
  end

  // Operand muxes; indices may sit at N_OPS, which selects nothing.
  always_comb begin
    dvd_sel = '0;
    dvs_sel = '0;
    dvd_neg = 1'b0;
    for (int i = 0; i < N_OPS; i++) begin
      if (dvd_idx_q == IW'(i)) dvd_sel = dvd_q[64*i +: 64];
      if (dvs_idx_q == IW'(i)) dvs_sel = dvs_q[64*i +: 64];
      if (ret_idx_q == IW'(i)) dvd_neg = dvd_q[64*i + 63];
    end
  end

  always_comb begin
    q_s = s_axis_dout_tdata[80:0];
    s_s = q_s >>> SH;
`ifdef DIV_RASTERIZER_CLIENT_SAT_EN
    if ((&s_s[80:OUT_W-1]) || !(|s_s[80:OUT_W-1]))
      conv = s_s[OUT_W-1:0];
    else
      conv = s_s[80] ? MINV : MAXV;
`else
    conv = s_s[OUT_W-1:0];
`endif
    if (s_axis_dout_tuser)
      conv = dvd_neg ? MINV : MAXV;
  end

  assign unused_bits = ^{s_axis_dout_tdata[87:81], s_s};

  assign dvd_vld = (state_q == S_ISSUE) && (dvd_idx_q < NI);
  assign dvs_vld = (state_q == S_ISSUE) && (dvs_idx_q < NI);
  assign ret_rdy = ((state_q == S_ISSUE) || (state_q == S_WAIT))
                   && (ret_idx_q < NI);
  assign dvd_hs  = dvd_vld && m_axis_dividend_tready;
  assign dvs_hs  = dvs_vld && m_axis_divisor_tready;
  assign ret_hs  = ret_rdy && s_axis_dout_tvalid;

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    dvd_idx_d = dvd_idx_q;
    dvs_idx_d = dvs_idx_q;
    ret_idx_d = ret_idx_q;
    res_d     = res_q;
    dbz_d     = dbz_q;
    if (dvd_hs) dvd_idx_d = dvd_idx_q + IW'(1);
    if (dvs_hs) dvs_idx_d = dvs_idx_q + IW'(1);
    if (ret_hs) begin
      for (int i = 0; i < N_OPS; i++) begin
        if (ret_idx_q == IW'(i)) begin
          res_d[OUT_W*i +: OUT_W] = conv;
          dbz_d[i] = s_axis_dout_tuser;
        end
      end
      ret_idx_d = ret_idx_q + IW'(1);
    end
    unique case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          dvd_d     = job_dividend;
          dvs_d     = job_divisor;
          dvd_idx_d = '0;
          dvs_idx_d = '0;
          ret_idx_d = '0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ret_idx_d == NI)
          state_d = S_OUT;
        else if ((dvd_idx_d == NI) && (dvs_idx_d == NI))
          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ret_idx_d == NI) state_d = S_OUT;
      end
      S_OUT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign job_ready              = (state_q == S_IDLE);
  assign busy                   = (state_q != S_IDLE);
  assign res_valid              = (state_q == S_OUT);
  assign res_data               = res_q;
  assign res_dbz                = dbz_q;
  assign m_axis_dividend_tvalid = dvd_vld;
  assign m_axis_dividend_tdata  = dvd_vld ? dvd_sel : '0;
  assign m_axis_divisor_tvalid  = dvs_vld;
  assign m_axis_divisor_tdata   = dvs_vld ? dvs_sel : '0;
  assign s_axis_dout_tready     = ret_rdy;

endmodule

// File: tb/tb_div_rasterizer_client.sv
// Bench for div_rasterizer_client with a behavioural fixed-latency divider.
// Expected bundles are queued at job issue and checked at bundle handshake.
module tb_div_rasterizer_client;

  localparam int N   = 3;
  localparam int OW  = 32;
  localparam int LAT = 4;
  localparam logic [OW-1:0] MAXV = 32'h7FFF_FFFF;
  localparam logic [OW-1:0] MINV = 32'h8000_0000;
  localparam logic signed [127:0] SMAX = 128'sd2147483647;
  localparam logic signed [127:0] SMIN = -SMAX - 128'sd1;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              job_valid;
  logic              job_ready;
  logic [N*64-1:0]   job_dividend;
  logic [N*64-1:0]   job_divisor;
  logic              m_dvd_tvalid, m_dvd_tready;
  logic [63:0]       m_dvd_tdata;
  logic              m_dvs_tvalid, m_dvs_tready;
  logic [63:0]       m_dvs_tdata;
  logic              s_tvalid, s_tready, s_tuser;
  logic [87:0]       s_tdata;
  logic              res_valid, res_ready;
  logic [N*OW-1:0]   res_data;
  logic [N-1:0]      res_dbz;
  logic              busy;

  always #5 aclk = ~aclk;

  div_rasterizer_client #(
    .N_OPS(N), .FRACTIONAL_WIDTH(17), .OUT_W(OW), .OUT_FRAC(16)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_dividend(job_dividend), .job_divisor(job_divisor),
    .m_axis_dividend_tvalid(m_dvd_tvalid),
    .m_axis_dividend_tready(m_dvd_tready),
    .m_axis_dividend_tdata(m_dvd_tdata),
    .m_axis_divisor_tvalid(m_dvs_tvalid),
    .m_axis_divisor_tready(m_dvs_tready),
    .m_axis_divisor_tdata(m_dvs_tdata),
    .s_axis_dout_tvalid(s_tvalid), .s_axis_dout_tready(s_tready),
    .s_axis_dout_tuser(s_tuser), .s_axis_dout_tdata(s_tdata),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_dbz(res_dbz), .busy(busy)
  );

  // Divider model
  typedef struct {
    logic [87:0] d;
    logic        u;
    int          t;
  } dres_t;

  logic [63:0]        dvd_fifo[$];
  logic [63:0]        dvs_fifo[$];
  dres_t              pipe[$];
  int                 cyc = 0;
  logic               dvs_stall = 1'b0;
  logic [63:0]        ma, mb;
  logic signed [127:0] sa, sb_, sq;
  dres_t              nr;

  always @(posedge aclk) begin
    cyc++;
    if (!aresetn) begin
      dvd_fifo.delete();
      dvs_fifo.delete();
      pipe.delete();
    end else begin
      if (m_dvd_tvalid && m_dvd_tready) dvd_fifo.push_back(m_dvd_tdata);
      if (m_dvs_tvalid && m_dvs_tready) dvs_fifo.push_back(m_dvs_tdata);
      if (s_tvalid && s_tready) void'(pipe.pop_front());
      if (dvd_fifo.size() > 0 && dvs_fifo.size() > 0) begin
        ma = dvd_fifo.pop_front();
        mb = dvs_fifo.pop_front();
        sa = {{64{ma[63]}}, ma};
        sb_ = {{64{mb[63]}}, mb};
        if (mb == 64'd0) begin
          nr.d = '0;
          nr.u = 1'b1;
        end else begin
          sq = (sa * 131072) / sb_;
          nr.d = sq[87:0];
          nr.u = 1'b0;
        end
        nr.t = cyc + LAT;
        pipe.push_back(nr);
      end
    end
  end

  always @(negedge aclk) begin
    m_dvd_tready = 1'b1;
    m_dvs_tready = !dvs_stall;
    if (pipe.size() > 0 && pipe[0].t <= cyc) begin
      s_tvalid = 1'b1;
      s_tdata  = pipe[0].d;
      s_tuser  = pipe[0].u;
    end else begin
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tuser  = 1'b0;
    end
  end

  // Scoreboard
  typedef struct {
    logic [N*OW-1:0] data;
    logic [N-1:0]    dbz;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [OW:0] exp_slot(input logic [63:0] dv,
                                           input logic [63:0] ds);
    logic signed [127:0] a, b, q, s;
    if (ds == 64'd0) return {1'b1, (dv[63] ? MINV : MAXV)};
    a = {{64{dv[63]}}, dv};
    b = {{64{ds[63]}}, ds};
    q = (a * 131072) / b;
    s = q >>> 1;
`ifdef DIV_RASTERIZER_CLIENT_SAT_EN
    if (s > SMAX) return {1'b0, MAXV};
    if (s < SMIN) return {1'b0, MINV};
`endif
    return {1'b0, s[OW-1:0]};
  endfunction

  task automatic send_job(input logic [N*64-1:0] dv, input logic [N*64-1:0] ds);
    exp_t e;
    logic [OW:0] r;
    int k = 0;
    while (!job_ready && k < 100) begin
      @(negedge aclk);
      k++;
    end
    n_tests++;
    if (!job_ready) begin
      n_fail++;
      $display("FAIL job_accept: job_ready=%b required 1", job_ready);
    end
    for (int i = 0; i < N; i++) begin
      r = exp_slot(dv[64*i +: 64], ds[64*i +: 64]);
      e.data[OW*i +: OW] = r[OW-1:0];
      e.dbz[i] = r[OW];
    end
    sbq.push_back(e);
    job_valid    = 1'b1;
    job_dividend = dv;
    job_divisor  = ds;
    @(negedge aclk);
    job_valid = 1'b0;
  endtask

  task automatic get_result(input int hold, input string name);
    exp_t e;
    logic [N*OW-1:0] held;
    int k = 0;
    while (!res_valid && k < 200) begin
      @(negedge aclk);
      k++;
    end
    n_tests++;
    if (!res_valid) begin
      n_fail++;
      $display("FAIL %s_timeout: res_valid=%b required 1", name, res_valid);
      return;
    end
    held = res_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge aclk);
      n_tests++;
      if ({res_valid, job_ready, res_data} !== {1'b1, 1'b0, held}) begin
        n_fail++;
        $display("FAIL %s_hold: valid=%b job_ready=%b data=%h required 1 0 %h",
                 name, res_valid, job_ready, res_data, held);
      end
    end
    n_tests++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL %s_sb: unexpected bundle %h", name, res_data);
    end else begin
      e = sbq.pop_front();
      if (res_data !== e.data) begin
        n_fail++;
        $display("FAIL %s_data: got %h required %h", name, res_data, e.data);
      end
      n_tests++;
      if (res_dbz !== e.dbz) begin
        n_fail++;
        $display("FAIL %s_dbz: got %b required %b", name, res_dbz, e.dbz);
      end
    end
    res_ready = 1'b1;
    @(negedge aclk);
    res_ready = 1'b0;
    n_tests++;
    if ({res_valid, job_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s_release: valid=%b job_ready=%b required 0 1",
               name, res_valid, job_ready);
    end
  endtask

  function automatic logic [63:0] s64(input longint v);
    return v;
  endfunction

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    n_tests++;
    if (job_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_job_ready: got %b required 1", job_ready);
    end
    n_tests++;
    if ({busy, res_valid, m_dvd_tvalid, m_dvs_tvalid, s_tready, res_dbz, res_data}
        !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b rv=%b dv=%b ds=%b rdy=%b dbz=%b data=%h required all 0",
               busy, res_valid, m_dvd_tvalid, m_dvs_tvalid, s_tready, res_dbz, res_data);
    end
  endtask

  task automatic test_basic();
    send_job({3{s64(10)}}, {3{s64(4)}});
    get_result(0, "basic");
  endtask

  task automatic test_mixed();
    send_job({s64(10), s64(-7), s64(10)}, {s64(4), s64(2), s64(4)});
    get_result(0, "mixed");
  endtask

  task automatic test_dbz();
    send_job({s64(10), s64(-5), s64(5)}, {s64(4), s64(0), s64(0)});
    get_result(0, "dbz");
  endtask

  task automatic test_big();
    send_job({s64(3), s64(-(64'sd1 <<< 40)), s64(64'sd1 <<< 40)},
             {s64(-2), s64(1), s64(1)});
    get_result(0, "big");
  endtask

  task automatic test_backpressure();
    dvs_stall = 1'b1;
    send_job({s64(10), s64(-7), s64(10)}, {s64(4), s64(2), s64(4)});
    repeat (5) @(negedge aclk);
    n_tests++;
    if ({m_dvd_tvalid, m_dvs_tvalid, m_dvs_tdata} !== {1'b0, 1'b1, s64(4)}) begin
      n_fail++;
      $display("FAIL bp_channels: dvd_v=%b dvs_v=%b dvs_d=%h required 0 1 4",
               m_dvd_tvalid, m_dvs_tvalid, m_dvs_tdata);
    end
    dvs_stall = 1'b0;
    get_result(3, "bp");
  endtask

  task automatic test_back_to_back();
    send_job({s64(9), s64(-1), s64(6)}, {s64(2), s64(8), s64(-3)});
    get_result(0, "b2b_a");
    send_job({s64(-3), s64(7), s64(1)}, {s64(4), s64(0), s64(16)});
    get_result(0, "b2b_b");
  endtask

  task automatic test_reset_midjob();
    int k = 0;
    send_job({3{s64(10)}}, {3{s64(4)}});
    while (!(busy && !m_dvd_tvalid && !m_dvs_tvalid && !res_valid) && k < 50) begin
      @(negedge aclk);
      k++;
    end
    n_tests++;
    if (!(busy && !m_dvd_tvalid && !m_dvs_tvalid && !res_valid)) begin
      n_fail++;
      $display("FAIL midrst_wait: busy=%b rv=%b required 1 0", busy, res_valid);
    end
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    void'(sbq.pop_back());
    n_tests++;
    if ({res_valid, busy, job_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL midrst_idle: rv=%b busy=%b jr=%b required 0 0 1",
               res_valid, busy, job_ready);
    end
    repeat (10) @(negedge aclk);
    n_tests++;
    if ({res_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_stray: rv=%b busy=%b required 0 0", res_valid, busy);
    end
    send_job({3{s64(10)}}, {3{s64(4)}});
    get_result(0, "midrst_next");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn      = 1'b0;
    job_valid    = 1'b0;
    job_dividend = '0;
    job_divisor  = '0;
    res_ready    = 1'b0;
    test_reset();
    test_basic();
    test_mixed();
    test_dbz();
    test_big();
    test_backpressure();
    test_back_to_back();
    test_reset_midjob();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
